// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blank and end-of-line/frame strobes decoded from the next counter state.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        line_end,
  output logic        frame_end,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] C_HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        r_line_end;
  logic        r_frame_end;
  logic [15:0] r_frame_count;

  logic        w_x_last;
  logic        w_y_last;
  logic [9:0]  w_x_next;
  logic [9:0]  w_y_next;

  assign w_x_last = (r_x == C_H_LAST);
  assign w_y_last = (r_y == C_V_LAST);

  always_comb begin
    w_x_next = r_x + 10'd1;
    w_y_next = r_y;
    if (w_x_last) begin
      w_x_next = 10'd0;
      w_y_next = w_y_last ? 10'd0 : r_y + 10'd1;
    end
  end

  // Strobes are decoded from the upcoming position so they land with it.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_line_end    <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_count <= 16'd0;
    end else if (ce) begin
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_hs        <= !((w_x_next >= C_HS_BEG) && (w_x_next < C_HS_END));
      r_vs        <= !((w_y_next >= C_VS_BEG) && (w_y_next < C_VS_END));
      r_blank     <= (w_x_next < C_H_ACT) && (w_y_next < C_V_ACT);
      r_line_end  <= (w_x_next == C_H_LAST);
      r_frame_end <= (w_x_next == C_H_LAST) && (w_y_next == C_V_LAST);
      if (w_x_last && w_y_last) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign line_end    = r_line_end;
  assign frame_end   = r_frame_end;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and a
// reduced-size instance for whole-frame, stall, reset and random-ce runs.
module tb_vga_timing_gen;

  // Reduced raster so full frames fit a short run.
  localparam int SHA = 20, SHF = 4, SHS = 6, SHB = 5;
  localparam int SVA = 12, SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 35
  localparam int SVT = SVA + SVF + SVS + SVB;   // 21

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, ce_d, rst_s, ce_s;
  logic [9:0]  dx_d, dy_d, dx_s, dy_s;
  logic        hs_d, vs_d, bl_d, le_d, fe_d;
  logic        hs_s, vs_s, bl_s, le_s, fe_s;
  logic [15:0] fc_d, fc_s;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset(rst_d), .ce(ce_d),
    .DrawX(dx_d), .DrawY(dy_d), .hs(hs_d), .vs(vs_d), .blank(bl_d),
    .line_end(le_d), .frame_end(fe_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_sml (
    .vga_clk(clk), .reset(rst_s), .ce(ce_s),
    .DrawX(dx_s), .DrawY(dy_s), .hs(hs_s), .vs(vs_s), .blank(bl_s),
    .line_end(le_s), .frame_end(fe_s), .frame_count(fc_s)
  );

  int checks = 0;
  int failures = 0;

  // Reference position of the small instance.
  int          mx, my;
  logic [15:0] mfc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_sml(input int x, input int y, input logic [15:0] fc);
    logic h, v, b, l, f;
    h = !(x >= SHA + SHF && x < SHA + SHF + SHS);
    v = !(y >= SVA + SVF && y < SVA + SVF + SVS);
    b = (x < SHA) && (y < SVA);
    l = (x == SHT - 1);
    f = (x == SHT - 1) && (y == SVT - 1);
    return {23'd0, 10'(x), 10'(y), h, v, b, l, f, fc};
  endfunction

  function automatic logic [63:0] obs_sml();
    return {23'd0, dx_s, dy_s, hs_s, vs_s, bl_s, le_s, fe_s, fc_s};
  endfunction

  task automatic model_adv();
    mx = (mx + 1) % SHT;
    if (mx == 0) begin
      my = (my + 1) % SVT;
      if (my == 0) mfc = mfc + 16'd1;
    end
  endtask

  task automatic sml_step(input logic c, input string tag);
    ce_s = c;
    @(posedge clk);
    #1;
    if (c) model_adv();
    chk(tag, obs_sml(), exp_sml(mx, my, mfc));
  endtask

  initial begin
    int le_cnt, hs_cnt, bl_cnt, vs_cnt, fe_cnt, steps, x, start_fc;
    rst_d = 1'b1; rst_s = 1'b1; ce_d = 1'b1; ce_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_def", {23'd0, dx_d, dy_d, hs_d, vs_d, bl_d, le_d, fe_d, fc_d},
        {23'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0});
    mx = 0; my = 0; mfc = 16'd0;
    chk("reset_sml", obs_sml(), exp_sml(0, 0, 16'd0));
    ce_d = 1'b0; ce_s = 1'b0;
    rst_d = 1'b0; rst_s = 1'b0;

    // One full default line.
    le_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      ce_d = 1'b1;
      @(posedge clk);
      #1;
      x = (i + 1) % 800;
      chk("line_x", {54'd0, dx_d}, 64'(x));
      chk("line_y", {54'd0, dy_d}, (i == 799) ? 64'd1 : 64'd0);
      chk("line_le", {63'd0, le_d}, {63'd0, (x == 799)});
      chk("line_hs", {63'd0, hs_d}, {63'd0, !(x >= 656 && x <= 751)});
      if (le_d) le_cnt++;
      if (!hs_d) hs_cnt++;
    end
    ce_d = 1'b0;
    chk("line_le_count", 64'(le_cnt), 64'd1);
    chk("line_hs_count", 64'(hs_cnt), 64'd96);

    // One full small frame.
    bl_cnt = 0; vs_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < SHT * SVT; i++) begin
      sml_step(1'b1, "frame");
      if (bl_s) bl_cnt++;
      if (!vs_s) vs_cnt++;
      if (fe_s) fe_cnt++;
    end
    chk("frame_blank_count", 64'(bl_cnt), 64'(SHA * SVA));
    chk("frame_vs_count", 64'(vs_cnt), 64'(SVS * SHT));
    chk("frame_fe_count", 64'(fe_cnt), 64'd1);
    chk("frame_count_1", {48'd0, fc_s}, 64'd1);

    // Stall across the frame end: ce 1,0,0,1 from (SHT-2, SVT-1).
    for (int i = 0; i < SHT * SVT - 2; i++) sml_step(1'b1, "to_fend");
    chk("pre_stall_pos", {44'd0, dx_s, dy_s}, {44'd0, 10'(SHT - 2), 10'(SVT - 1)});
    sml_step(1'b1, "stall_a");
    chk("stall_fe_a", {63'd0, fe_s}, 64'd1);
    sml_step(1'b0, "stall_b");
    chk("stall_fe_b", {63'd0, fe_s}, 64'd1);
    sml_step(1'b0, "stall_c");
    chk("stall_fe_c", {63'd0, fe_s}, 64'd1);
    sml_step(1'b1, "stall_d");
    chk("stall_wrap", {40'd0, dx_s, dy_s, bl_s, hs_s, vs_s, fe_s, fc_s},
        {40'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2});

    // Asynchronous reset mid-frame at (10,8).
    for (int i = 0; i < 8 * SHT + 10; i++) sml_step(1'b1, "to_mid");
    ce_s = 1'b0;
    #2 rst_s = 1'b1;
    #2;
    mx = 0; my = 0; mfc = 16'd0;
    chk("async_reset", obs_sml(), exp_sml(0, 0, 16'd0));
    #2 rst_s = 1'b0;
    sml_step(1'b1, "resume_first");
    chk("resume_pos", {44'd0, dx_s, dy_s}, {44'd0, 10'd1, 10'd0});

    // frame_count wrap from 16'hFFFF.
    for (int i = 0; i < SHT * SVT - 1; i++) sml_step(1'b1, "to_origin");
    ce_s = 1'b0;
    force u_sml.r_frame_count = 16'hFFFF;
    #1;
    release u_sml.r_frame_count;
    mfc = 16'hFFFF;
    sml_step(1'b0, "preload");
    for (int i = 0; i < SHT * SVT; i++) sml_step(1'b1, "wrap_run");
    chk("fc_wrap_zero", {48'd0, fc_s}, 64'd0);

    // Random ce over two frames, bounded.
    start_fc = int'(mfc);
    steps = 0;
    while (int'(mfc) != ((start_fc + 2) & 16'hFFFF) && steps < 20000) begin
      sml_step(1'($urandom_range(0, 1)), "random");
      steps++;
    end
    chk("random_two_frames", 64'(mfc), 64'((start_fc + 2) & 16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
